vga_frame_fetcher: RTL and testbench

Parametrised framebuffer read engine for the VGA pipeline, in the sys_clk domain between the framebuffer's pixel-read Avalon port and the write side of the VGA prefetch FIFO. It walks a full frame at a runtime-selectable base address, with double buffering via page flip committed only at frame boundaries. It keeps up to MAX_READ pipelined reads in flight and uses FIFO free-space credits, so the FIFO can never overflow. It supports packed words holding PIX_PER_WORD pixels, and a clean stop/restart through `enable`.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_fetch_addr_gen.sv | 70 +++++++
 rtl/vga_frame_fetcher.sv | 147 ++++++++++++++
 tb/tb_vga_frame_fetcher.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: default resolution, framebuffer fetch FSM
// encoding and line-geometry helpers.
package vga_pkg;

    // Default visible resolution, shared with vga_sync.
    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned V_DISPLAY_DEF = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Memory words needed to cover one visible line.
    function automatic int unsigned words_per_line(input int unsigned h_display,
                                                   input int unsigned pix_per_word);
        return h_display / pix_per_word;
    endfunction

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Frame walker for the fetcher: owns column, row and accumulated line offset,
// and forms the word address without a multiplier.
module vga_fetch_addr_gen
    import vga_pkg::*;
#(
    parameter int unsigned AVN_AW    = 19,
    parameter int unsigned WPL       = 640,
    parameter int unsigned V_DISPLAY = 480
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              launch,
    input  logic              advance,
    input  logic [AVN_AW-1:0] frame_base,
    output logic              frame_end,
    output logic [AVN_AW-1:0] address
);

    localparam int unsigned COL_W = cnt_width(WPL);
    localparam int unsigned ROW_W = cnt_width(V_DISPLAY);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WPL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_DISPLAY - 1);
    localparam logic [AVN_AW-1:0] LINE_STEP = AVN_AW'(WPL);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [AVN_AW-1:0] line_base_q, line_base_d;
    logic              line_end;

    assign line_end  = (col_q == COL_LAST);
    assign frame_end = line_end && (row_q == ROW_LAST);
    assign address   = frame_base + line_base_q + AVN_AW'(col_q);

    // Launch wins over advance so a back-to-back frame starts cleanly at 0,0.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        line_base_d = line_base_q;
        if (launch) begin
            col_d       = '0;
            row_d       = '0;
            line_base_d = '0;
        end else if (advance) begin
            if (!line_end) begin
                col_d = col_q + COL_W'(1);
            end else if (frame_end) begin
                col_d       = '0;
                row_d       = '0;
                line_base_d = '0;
            end else begin
                col_d       = '0;
                row_d       = row_q + ROW_W'(1);
                line_base_d = line_base_q + LINE_STEP;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            line_base_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            line_base_q <= line_base_d;
        end
    end

endmodule

// File: rtl/vga_frame_fetcher.sv
// Framebuffer read engine: walks whole frames over Avalon with pipelined reads,
// FIFO credit flow control and frame-boundary page flipping.
module vga_frame_fetcher
    import vga_pkg::*;
#(
    parameter int unsigned AVN_AW       = 19,
    parameter int unsigned AVN_DW       = 16,
    parameter int unsigned H_DISPLAY    = H_DISPLAY_DEF,
    parameter int unsigned V_DISPLAY    = V_DISPLAY_DEF,
    parameter int unsigned PIX_PER_WORD = 1,
    parameter int unsigned MAX_READ     = 4,
    parameter int unsigned BUF_SIZE     = 32
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         enable,
    input  logic [AVN_AW-1:0]            fb_base0,
    input  logic [AVN_AW-1:0]            fb_base1,
    input  logic                         flip_req,
    output logic                         front_sel,
    output logic                         flip_done,
    output logic                         frame_start,
    output logic                         busy,
    output logic                         pxl_avn_read,
    output logic [AVN_AW-1:0]            pxl_avn_address,
    input  logic [AVN_DW-1:0]            pxl_avn_readdata,
    input  logic                         pxl_avn_readdatavalid,
    input  logic                         pxl_avn_waitrequest,
    input  logic [$clog2(BUF_SIZE+1)-1:0] fifo_space,
    output logic                         fifo_write,
    output logic [AVN_DW-1:0]            fifo_din
);

    localparam int unsigned WPL   = words_per_line(H_DISPLAY, PIX_PER_WORD);
    localparam int unsigned CNT_W = $clog2(MAX_READ + 1);

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             front_sel_q, front_sel_d;
    logic             flip_pend_q, flip_pend_d;
    logic             flip_done_q, flip_done_d;
    logic             first_q, first_d;

    logic              can_issue;
    logic              fire;
    logic              launch;
    logic              apply_flip;
    logic              frame_end;
    logic [AVN_AW-1:0] frame_base;

    // Outstanding reads already own FIFO slots, so only the remainder is credit.
    assign can_issue    = (32'(out_cnt_q) < MAX_READ) && (32'(fifo_space) > 32'(out_cnt_q));
    assign pxl_avn_read = (state_q == FETCH) && can_issue;
    assign fire         = pxl_avn_read && !pxl_avn_waitrequest;

    // front_sel only changes at a launch, so it doubles as the latched frame base select.
    assign frame_base = front_sel_q ? fb_base1 : fb_base0;

    assign front_sel   = front_sel_q;
    assign flip_done   = flip_done_q;
    assign frame_start = fire && first_q;
    assign busy        = (state_q != IDLE);
    assign fifo_write  = pxl_avn_readdatavalid;
    assign fifo_din    = pxl_avn_readdata;

    vga_fetch_addr_gen #(
        .AVN_AW    (AVN_AW),
        .WPL       (WPL),
        .V_DISPLAY (V_DISPLAY)
    ) u_addr_gen (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .launch     (launch),
        .advance    (fire),
        .frame_base (frame_base),
        .frame_end  (frame_end),
        .address    (pxl_avn_address)
    );

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    launch  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A read stalled by waitrequest when enable drops was never accepted.
                if (!enable) begin
                    state_d = DRAIN;
                end else if (fire && frame_end) begin
                    launch = 1'b1;
                end
            end
            DRAIN: begin
                if (out_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apply_flip  = launch && flip_pend_q;
        front_sel_d = front_sel_q ^ apply_flip;
        flip_done_d = apply_flip;
        // A request coinciding with an application is held for the following frame.
        flip_pend_d = apply_flip ? flip_req : (flip_pend_q || flip_req);

        first_d = first_q;
        if (launch) begin
            first_d = 1'b1;
        end else if (fire) begin
            first_d = 1'b0;
        end

        out_cnt_d = out_cnt_q;
        unique case ({fire, pxl_avn_readdatavalid})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            out_cnt_q   <= '0;
            front_sel_q <= 1'b0;
            flip_pend_q <= 1'b0;
            flip_done_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            front_sel_q <= front_sel_d;
            flip_pend_q <= flip_pend_d;
            flip_done_q <= flip_done_d;
            first_q     <= first_d;
        end
    end

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Bench for vga_frame_fetcher: 8x2 frame of 2-pixel words, fixed-latency memory
// model and a scoreboard of expected FIFO writes.
module tb_vga_frame_fetcher;

    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXR = 4;
    localparam int          WPF  = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          enable;
    logic [AW-1:0] fb_base0;
    logic [AW-1:0] fb_base1;
    logic          flip_req;
    logic          front_sel;
    logic          flip_done;
    logic          frame_start;
    logic          busy;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] readdata;
    logic          rdv;
    logic          waitrequest;
    logic [5:0]    fifo_space;
    logic          fifo_write;
    logic [DW-1:0] fifo_din;

    vga_frame_fetcher #(
        .AVN_AW       (AW),
        .AVN_DW       (DW),
        .H_DISPLAY    (8),
        .V_DISPLAY    (2),
        .PIX_PER_WORD (2),
        .MAX_READ     (MAXR),
        .BUF_SIZE     (32)
    ) dut (
        .sys_clk               (sys_clk),
        .sys_rst               (sys_rst),
        .enable                (enable),
        .fb_base0              (fb_base0),
        .fb_base1              (fb_base1),
        .flip_req              (flip_req),
        .front_sel             (front_sel),
        .flip_done             (flip_done),
        .frame_start           (frame_start),
        .busy                  (busy),
        .pxl_avn_read          (rd),
        .pxl_avn_address       (addr),
        .pxl_avn_readdata      (readdata),
        .pxl_avn_readdatavalid (rdv),
        .pxl_avn_waitrequest   (waitrequest),
        .fifo_space            (fifo_space),
        .fifo_write            (fifo_write),
        .fifo_din              (fifo_din)
    );

    initial forever #5 sys_clk = ~sys_clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } mem_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            lat = 1;
    bit            rand_wait = 0;
    bit            force_wait = 0;
    bit            stall_chk = 0;
    mem_t          pipe[$];
    logic [DW-1:0] exp_q[$];
    int            m_idx = 0;
    int            m_out = 0;
    int            m_max = 0;
    int            m_lim = 4;
    int            fire_cnt = 0;
    bit            m_front = 0;
    bit            m_flip_pend = 0;
    bit            m_flip_due = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [AW-1:0] m_base();
        return m_front ? fb_base1 : fb_base0;
    endfunction

    // Memory: fixed latency, in-order returns, optional random waitrequest.
    initial begin
        waitrequest = 1'b0;
        rdv         = 1'b0;
        readdata    = '0;
        forever begin
            @(posedge sys_clk);
            cyc++;
            #1;
            if (sys_rst) begin
                pipe.delete();
                rdv         = 1'b0;
                waitrequest = 1'b0;
            end else begin
                waitrequest = force_wait || (rand_wait && ($urandom_range(0, 1) == 1));
                if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                    rdv      = 1'b1;
                    readdata = pipe[0].data;
                    void'(pipe.pop_front());
                end else begin
                    rdv      = 1'b0;
                    readdata = '0;
                end
            end
        end
    end

    // Monitor: address model, credit bounds, pulses and FIFO scoreboard.
    initial begin
        logic          fire_s;
        logic [AW-1:0] exp_a;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                fire_s = rd && !waitrequest;
                chk("frame_start", frame_start, fire_s && (m_idx == 0));
                chk("flip_done", flip_done, m_flip_due);
                m_flip_due = 0;
                chk("credit_bound", m_out <= m_lim, 1);
                if (m_out >= m_lim) chk("read_at_limit", rd, 0);
                if (stall_chk && prev_stall) begin
                    chk("stall_read", rd, 1);
                    chk("stall_addr", addr, prev_addr);
                end
                prev_stall = rd && waitrequest;
                prev_addr  = addr;
                if (fire_s) begin
                    exp_a = m_base() + AW'(m_idx);
                    chk("address", addr, exp_a);
                    if (m_idx == 0) chk("front_sel", front_sel, m_front);
                    pipe.push_back('{due: cyc + lat, data: mdata(addr)});
                    exp_q.push_back(mdata(exp_a));
                    fire_cnt++;
                    m_idx++;
                    if (m_idx == WPF) begin
                        m_idx = 0;
                        if (m_flip_pend && enable) begin
                            m_front     = ~m_front;
                            m_flip_pend = 0;
                            m_flip_due  = 1;
                        end
                    end
                end
                if (fifo_write) begin
                    if (exp_q.size() == 0) chk("fifo_unexpected", fifo_write, 0);
                    else chk("fifo_din", fifo_din, exp_q.pop_front());
                end
                m_out = m_out + int'(fire_s) - int'(fifo_write);
                if (m_out > m_max) m_max = m_out;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic start_run();
        m_idx  = 0;
        enable = 1'b1;
        chk("start_idle_read", rd, 0);
        step(1);
        chk("start_read", rd, 1);
        chk("start_addr", addr, m_base());
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) step(1);
        chk(tag, busy, 0);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_out_zero"}, m_out, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"}, rd, 0);
        chk({tag, "_addr"}, addr, fb_base0);
        chk({tag, "_front"}, front_sel, 0);
        chk({tag, "_flip_done"}, flip_done, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fifo_write"}, fifo_write, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        fb_base0   = 19'h100;
        fb_base1   = 19'h800;
        enable     = 1'b0;
        flip_req   = 1'b0;
        fifo_space = 6'd32;
        sys_rst    = 1'b1;
        step(2);
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        step(1);

        // Back-to-back frames at full rate with single-cycle memory.
        lat = 1;
        start_run();
        step(2);
        f0 = fire_cnt;
        step(16);
        chk("throughput", fire_cnt - f0, 16);
        enable = 1'b0;
        wait_idle("t1_idle");

        // Long latency: limited by MAX_READ.
        lat   = 6;
        m_max = 0;
        start_run();
        step(30);
        chk("max_out_maxread", m_max, MAXR);
        enable = 1'b0;
        wait_idle("t2_idle");

        // FIFO credit limit of 2.
        fifo_space = 6'd2;
        m_lim      = 2;
        m_max      = 0;
        start_run();
        step(30);
        chk("max_out_space", m_max, 2);
        enable = 1'b0;
        wait_idle("t3_idle");
        fifo_space = 6'd32;
        m_lim      = 4;

        // Drop enable at col 3 with the col-3 request stalled.
        start_run();
        for (int i = 0; i < 20 && m_idx != 3; i++) begin
            @(negedge sys_clk);
            #1;
        end
        chk("drop_outstanding", m_out, 3);
        force_wait = 1'b1;
        step(1);
        enable = 1'b0;
        chk("drop_stalled_read", rd, 1);
        f0 = fire_cnt;
        step(1);
        chk("drain_busy", busy, 1);
        chk("drain_read", rd, 0);
        wait_idle("t5_idle");
        chk("drain_no_new_reads", fire_cnt, f0);
        force_wait = 1'b0;
        step(1);
        start_run();
        step(10);
        enable = 1'b0;
        wait_idle("t5b_idle");

        // Page flip requested mid-frame.
        lat = 1;
        start_run();
        for (int i = 0; i < 40 && m_idx != 2; i++) step(1);
        flip_req    = 1'b1;
        m_flip_pend = 1;
        step(1);
        flip_req = 1'b0;
        step(20);
        chk("front_sel_after_flip", front_sel, 1);
        enable = 1'b0;
        wait_idle("t4_idle");

        // Random stalls, then asynchronous reset mid-frame.
        lat = 2;
        start_run();
        rand_wait = 1;
        stall_chk = 1;
        step(13);
        #1;
        sys_rst = 1'b1;
        exp_q.delete();
        m_idx       = 0;
        m_out       = 0;
        m_front     = 0;
        m_flip_pend = 0;
        m_flip_due  = 0;
        prev_stall  = 0;
        rand_wait   = 0;
        stall_chk   = 0;
        enable      = 1'b0;
        #1;
        chk("async_rst_read", rd, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_front", front_sel, 0);
        step(2);
        check_reset_outputs("mid_reset");
        sys_rst = 1'b0;
        step(2);
        check_reset_outputs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
